// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared types and defaults for the data-memory arbiter.
//   arb_state_t : owner of the memory port in the previous cycle.
//   req_id_t    : requester identity, used to remember the most recent winner.
//   DEFAULT_MAX_BURST : default burst bound before the owner must yield.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef enum logic {
    R0 = 1'b0,
    R1 = 1'b1
  } req_id_t;

  localparam int DEFAULT_MAX_BURST = 4;

endpackage

// File: rtl/dmem_arb_perf.sv
// dmem_arb_perf
//   Saturating performance counters for the data-memory arbiter.
//   Only built when DMEM_ARB_PERF_EN is defined.
// Ports
//   clk, rst            : clock, async active-high reset (clears all counters)
//   gnt0, gnt1          : a beat was granted to r0 / r1 this cycle
//   conflict            : both requesters asked this cycle
//   r0_gnt_cnt          : number of beats granted to r0
//   r1_gnt_cnt          : number of beats granted to r1
//   conflict_cnt        : number of contested cycles
`ifdef DMEM_ARB_PERF_EN
module dmem_arb_perf #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gnt0,
  input  logic             gnt1,
  input  logic             conflict,
  output logic [CNT_W-1:0] r0_gnt_cnt,
  output logic [CNT_W-1:0] r1_gnt_cnt,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Each counter sticks at all-ones instead of wrapping, so a long run
  // never reports a misleadingly small value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_gnt_cnt   <= '0;
      r1_gnt_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt0 && (r0_gnt_cnt != '1))
        r0_gnt_cnt <= r0_gnt_cnt + CNT_ONE;
      if (gnt1 && (r1_gnt_cnt != '1))
        r1_gnt_cnt <= r1_gnt_cnt + CNT_ONE;
      if (conflict && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + CNT_ONE;
    end
  end

endmodule
`endif

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port data memory between r0 (core load/store) and
//   r1 (debug/DMA loader). Round-robin with a bounded burst: the owner keeps
//   the port for up to MAX_BURST consecutive beats, then yields if the other
//   requester is waiting. Memory read data is combinational; each requester
//   gets its read data registered one cycle after the grant.
// Configuration macro
//   DMEM_ARB_PERF_EN : adds saturating perf counters (CNT_W wide) and their
//                      output ports. Arbitration is identical either way.
// Ports
//   clk, rst                       : clock, async active-high reset
//   rX_req/we/addr/wdata           : request from requester X (held until gnt)
//   rX_gnt                         : combinational grant, one beat this cycle
//   rX_rvalid/rdata                : registered read return (1-cycle pulse)
//   mem_a/mem_wd/mem_we            : memory address/write data/write enable
//   mem_rd                         : memory combinational read data
//   busy                           : arbiter is not IDLE
//   r0_gnt_cnt/r1_gnt_cnt/conflict_cnt : perf counters (DMEM_ARB_PERF_EN only)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
`ifdef DMEM_ARB_PERF_EN
  ,
  parameter int CNT_W     = 16
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0] r0_gnt_cnt,
  output logic [CNT_W-1:0] r1_gnt_cnt,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  // Beat counter must be able to hold MAX_BURST itself.
  localparam int BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BURST);
  localparam logic [BW-1:0] BEAT_ONE = BW'(1);

  arb_state_t    state, state_n;
  req_id_t       last, last_n;
  logic [BW-1:0] beat, beat_n;
  logic          gnt0, gnt1;

  // Grant decision and next-state. The owner keeps the port while its burst
  // budget lasts or nobody else is waiting. Grants are suppressed while rst is
  // high so no write reaches memory during the reset cycle.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_n = state;
    last_n  = last;
    beat_n  = beat;

    case (state)
      IDLE: begin
        if (r0_req && (!r1_req || (last == R1)))
          gnt0 = 1'b1;
        else if (r1_req)
          gnt1 = 1'b1;
      end
      OWN0: begin
        if (r0_req && ((beat < BEAT_MAX) || !r1_req))
          gnt0 = 1'b1;
        else if (r1_req)
          gnt1 = 1'b1;
      end
      OWN1: begin
        if (r1_req && ((beat < BEAT_MAX) || !r0_req))
          gnt1 = 1'b1;
        else if (r0_req)
          gnt0 = 1'b1;
      end
      default: ;
    endcase

    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    // A continuing owner extends its burst (capped); a new owner starts at 1.
    if (gnt0) begin
      state_n = OWN0;
      last_n  = R0;
      if (state == OWN0)
        beat_n = (beat == BEAT_MAX) ? BEAT_MAX : beat + BEAT_ONE;
      else
        beat_n = BEAT_ONE;
    end else if (gnt1) begin
      state_n = OWN1;
      last_n  = R1;
      if (state == OWN1)
        beat_n = (beat == BEAT_MAX) ? BEAT_MAX : beat + BEAT_ONE;
      else
        beat_n = BEAT_ONE;
    end else begin
      state_n = IDLE;
      beat_n  = '0;
    end
  end

  // Memory port mux: idle port is driven to zero.
  always_comb begin
    mem_a  = '0;
    mem_wd = '0;
    mem_we = 1'b0;
    if (gnt0) begin
      mem_a  = r0_addr;
      mem_wd = r0_wdata;
      mem_we = r0_we;
    end else if (gnt1) begin
      mem_a  = r1_addr;
      mem_wd = r1_wdata;
      mem_we = r1_we;
    end
  end

  assign r0_gnt = gnt0;
  assign r1_gnt = gnt1;
  assign busy   = (state != IDLE);

  // Arbitration state plus registered read return. rdata only updates on a
  // granted read so it holds the last value between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= R1;
      beat      <= '0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      beat      <= beat_n;
      r0_rvalid <= gnt0 && !r0_we;
      r1_rvalid <= gnt1 && !r1_we;
      if (gnt0 && !r0_we)
        r0_rdata <= mem_rd;
      if (gnt1 && !r1_we)
        r1_rdata <= mem_rd;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  dmem_arb_perf #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk          (clk),
    .rst          (rst),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .conflict     (r0_req && r1_req),
    .r0_gnt_cnt   (r0_gnt_cnt),
    .r1_gnt_cnt   (r1_gnt_cnt),
    .conflict_cnt (conflict_cnt)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a 256-word behavioural memory.
//   Inputs change just after the falling edge; combinational outputs are
//   sampled there, registered outputs 1 time unit after the rising edge.
//   With DMEM_ARB_PERF_EN defined the counters are built 4 bits wide so
//   saturation can be reached quickly.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r0_req, r0_we, r1_req, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd, mem_rd;
  logic          mem_we, busy;
`ifdef DMEM_ARB_PERF_EN
  logic [3:0]    r0_gnt_cnt, r1_gnt_cnt, conflict_cnt;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .AW(AW),
    .DW(DW),
    .MAX_BURST(4)
`ifdef DMEM_ARB_PERF_EN
    ,
    .CNT_W(4)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .r0_req    (r0_req),
    .r0_we     (r0_we),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_gnt    (r0_gnt),
    .r0_rvalid (r0_rvalid),
    .r0_rdata  (r0_rdata),
    .r1_req    (r1_req),
    .r1_we     (r1_we),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_gnt    (r1_gnt),
    .r1_rvalid (r1_rvalid),
    .r1_rdata  (r1_rdata),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .mem_we    (mem_we),
    .mem_rd    (mem_rd),
    .busy      (busy)
`ifdef DMEM_ARB_PERF_EN
    ,
    .r0_gnt_cnt   (r0_gnt_cnt),
    .r1_gnt_cnt   (r1_gnt_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  // Behavioural memory: decodes the low 8 address bits, combinational read.
  // The first clock edge fills it with a recognisable per-address pattern.
  logic [DW-1:0] mem [0:255];
  bit            memReady = 1'b0;

  function automatic logic [31:0] memInit(input logic [7:0] a);
    return 32'hA5A5_0000 | {24'h0, a};
  endfunction

  always @(posedge clk) begin
    if (!memReady) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= memInit(8'(i));
      memReady <= 1'b1;
    end else if (mem_we) begin
      mem[mem_a[7:0]] <= mem_wd;
    end
  end

  assign mem_rd = mem[mem_a[7:0]];

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic q0, input logic w0,
                               input logic [31:0] a0, input logic [31:0] d0,
                               input logic q1, input logic w1,
                               input logic [31:0] a1, input logic [31:0] d1);
    @(negedge clk);
    r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
    r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp0;
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;

    // Power-on reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_r0_rvalid", r0_rvalid, 0);
    checkOutput("rst_r1_rvalid", r1_rvalid, 0);
    checkOutput("rst_r0_rdata", r0_rdata, 0);
    checkOutput("rst_r1_rdata", r1_rdata, 0);
    @(negedge clk);
    rst = 1'b0;

    // Solo r0: write then read back
    applyStimulus(1, 1, 32'h02, 32'hDEADBEEF, 0, 0, 0, 0);
    checkOutput("w_r0_gnt", r0_gnt, 1);
    checkOutput("w_r1_gnt", r1_gnt, 0);
    checkOutput("w_mem_we", mem_we, 1);
    checkOutput("w_mem_a", mem_a, 32'h02);
    checkOutput("w_mem_wd", mem_wd, 32'hDEADBEEF);
    tick();
    checkOutput("w_no_rvalid", r0_rvalid, 0);
    checkOutput("w_busy", busy, 1);
    checkOutput("w_committed", mem[8'h02], 32'hDEADBEEF);
    applyStimulus(1, 0, 32'h02, 0, 0, 0, 0, 0);
    checkOutput("rd_r0_gnt", r0_gnt, 1);
    checkOutput("rd_mem_we", mem_we, 0);
    tick();
    checkOutput("rd_r0_rvalid", r0_rvalid, 1);
    checkOutput("rd_r0_rdata", r0_rdata, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("idle_r0_gnt", r0_gnt, 0);
    checkOutput("idle_mem_a", mem_a, 0);
    tick();
    checkOutput("idle_rvalid_pulse", r0_rvalid, 0);
    checkOutput("idle_rdata_hold", r0_rdata, 32'hDEADBEEF);
    checkOutput("idle_busy", busy, 0);

    // r0 won last, so a tie now goes to r1; reset lands mid-burst
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 32'h20, 0, 1, 0, 32'h30, 0);
      checkOutput("pre_r1_gnt", r1_gnt, 1);
      checkOutput("pre_r0_gnt", r0_gnt, 0);
      tick();
      checkOutput("pre_r1_rvalid", r1_rvalid, 1);
      checkOutput("pre_r1_rdata", r1_rdata, memInit(8'h30));
    end
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_rvalid", r1_rvalid, 0);
    checkOutput("mid_rst_rdata", r1_rdata, 0);
    checkOutput("mid_rst_busy", busy, 0);
    applyStimulus(1, 0, 32'h20, 0, 1, 1, 32'h30, 32'h12345678);
    checkOutput("mid_rst_r0_gnt", r0_gnt, 0);
    checkOutput("mid_rst_r1_gnt", r1_gnt, 0);
    checkOutput("mid_rst_mem_we", mem_we, 0);
    tick();
    checkOutput("mid_rst_no_write", mem[8'h30], memInit(8'h30));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Contested continuous reads: r0 x4, r1 x4, r0 x4 (r0 wins first tie)
    for (int i = 0; i < 12; i++) begin
      exp0 = ((i / 4) % 2) == 0;
      applyStimulus(1, 0, 32'h20, 0, 1, 0, 32'h30, 0);
      checkOutput("rr_r0_gnt", r0_gnt, exp0);
      checkOutput("rr_r1_gnt", r1_gnt, !exp0);
      checkOutput("rr_mem_a", mem_a, exp0 ? 32'h20 : 32'h30);
      tick();
      checkOutput("rr_r0_rvalid", r0_rvalid, exp0);
      checkOutput("rr_r1_rvalid", r1_rvalid, !exp0);
      if (exp0)
        checkOutput("rr_r0_rdata", r0_rdata, memInit(8'h20));
      else
        checkOutput("rr_r1_rdata", r1_rdata, memInit(8'h30));
    end

    // Owner drops at beat 2 while r1 waits; r1 then gets a fresh burst of 4
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("drop_idle_gnt", r0_gnt | r1_gnt, 0);
    checkOutput("drop_idle_we", mem_we, 0);
    tick();
    checkOutput("drop_idle_busy", busy, 0);
    applyStimulus(1, 0, 32'h20, 0, 0, 0, 0, 0);
    checkOutput("drop_b1_r0", r0_gnt, 1);
    tick();
    applyStimulus(1, 0, 32'h20, 0, 1, 0, 32'h30, 0);
    checkOutput("drop_b2_r0", r0_gnt, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h30, 0);
    checkOutput("drop_handover_r1", r1_gnt, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 32'h20, 0, 1, 0, 32'h30, 0);
      checkOutput("drop_r1_burst", r1_gnt, 1);
      tick();
    end
    applyStimulus(1, 0, 32'h20, 0, 1, 0, 32'h30, 0);
    checkOutput("drop_back_r0", r0_gnt, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("drop_none_gnt", r0_gnt | r1_gnt, 0);
    checkOutput("drop_none_we", mem_we, 0);
    tick();
    checkOutput("drop_none_busy", busy, 0);

    // Same address: r1 write wins the tie (r0 won last), r0 read follows
    applyStimulus(1, 0, 32'h10, 0, 1, 1, 32'h10, 32'h55);
    checkOutput("raw_r1_gnt", r1_gnt, 1);
    checkOutput("raw_r0_wait", r0_gnt, 0);
    checkOutput("raw_mem_wd", mem_wd, 32'h55);
    tick();
    applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0);
    checkOutput("raw_r0_gnt", r0_gnt, 1);
    tick();
    checkOutput("raw_r0_rvalid", r0_rvalid, 1);
    checkOutput("raw_r0_rdata", r0_rdata, 32'h55);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

`ifdef DMEM_ARB_PERF_EN
    // Counters: 10 contested cycles, then 10 more to saturate conflict_cnt
    rst = 1'b1;
    #1;
    checkOutput("perf_rst_conflict", conflict_cnt, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 32'h20, 0, 1, 0, 32'h30, 0);
      tick();
    end
    checkOutput("perf_conflict_10", conflict_cnt, 10);
    checkOutput("perf_r0_6", r0_gnt_cnt, 6);
    checkOutput("perf_r1_4", r1_gnt_cnt, 4);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 32'h20, 0, 1, 0, 32'h30, 0);
      tick();
    end
    checkOutput("perf_conflict_sat", conflict_cnt, 15);
    checkOutput("perf_r0_12", r0_gnt_cnt, 12);
    checkOutput("perf_r1_8", r1_gnt_cnt, 8);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
